// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time writer.
//  - default RTC register addresses and the transfer-command data byte
//  - bus-state encoding of the write sequencer
//  - hour_byte(): hour register value for 12 h / 24 h format
package rtc_pkg;

  localparam logic [7:0] ADDR_SEC_DEF  = 8'h21;
  localparam logic [7:0] ADDR_MIN_DEF  = 8'h22;
  localparam logic [7:0] ADDR_HOUR_DEF = 8'h23;
  localparam logic [7:0] ADDR_CMD_DEF  = 8'hF2;
  localparam logic [7:0] CMD_DATA      = 8'hFF;

  // Index of the last transaction (SEC=0, MIN=1, HOUR=2, CMD=3).
  localparam logic [1:0] LAST_IDX = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_WR  = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_WR  = 3'd5,
    D_HLD = 3'd6
  } bus_state_t;

  // In 12 h mode the RTC wants the PM flag in bit 5 and the BCD hour in
  // bits 4:0; in 24 h mode the editor's byte goes through untouched.
  function automatic logic [7:0] hour_byte(input logic [7:0] h,
                                           input logic       ampm,
                                           input logic       fmt12);
    return fmt12 ? {2'b00, ampm, h[4:0]} : h;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus-phase timer: counts 0..T_PHASE-1 and flags the last cycle of a phase.
// Ports:
//  clk       in  system clock
//  reset     in  asynchronous active-high reset
//  restart   in  reload the count to 0 (asserted on every state change)
//  phase_end out high while the count is T_PHASE-1
module rtc_phase_timer #(
  parameter int T_PHASE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  logic [7:0] cnt;

  assign phase_end = (cnt == 8'(T_PHASE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_time_writer.sv
// Commits the edited time into the RTC over its multiplexed A/D write bus.
// Four write transactions (SEC, MIN, HOUR, CMD) each made of six bus
// phases of T_PHASE cycles, then a one-cycle done pulse.
//
// Handshake: start is a single-cycle request honoured only while idle;
// busy is high from the cycle after an accepted start until done; done
// pulses for one cycle as the last transaction finishes. Requests made
// while busy are dropped.
//
// Ports:
//  clk, reset         clock, asynchronous active-high reset
//  start              commit request
//  H, M, S            BCD hours/minutes/seconds from the editor
//  ampm, format       PM flag, 1 = 12 h format
//  ad_out/ad_oe       bus value and output enable
//  ad_sel             1 = address phase, 0 = data phase
//  cs_n, wr_n, rd_n   RTC strobes (rd_n held high)
//  busy, done         status
//  state_dbg          current sequencer state
module rtc_time_writer
  import rtc_pkg::*;
#(
  parameter int         T_PHASE   = 10,
  parameter logic [7:0] ADDR_SEC  = ADDR_SEC_DEF,
  parameter logic [7:0] ADDR_MIN  = ADDR_MIN_DEF,
  parameter logic [7:0] ADDR_HOUR = ADDR_HOUR_DEF,
  parameter logic [7:0] ADDR_CMD  = ADDR_CMD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] H,
  input  logic [7:0] M,
  input  logic [7:0] S,
  input  logic       ampm,
  input  logic       format,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  bus_state_t state, state_next;
  logic [1:0] idx, idx_next;
  logic [7:0] snap_sec, snap_min, snap_hour;
  logic       phase_end, restart;
  logic [7:0] nxt_addr, nxt_data;
  logic       nxt_strobe, nxt_addr_ph, nxt_data_ph;

  // Reload the phase counter whenever the state moves, and hold it at 0
  // while idle so the first phase of a transfer is full length.
  assign restart   = (state == IDLE) || (state_next != state);
  assign rd_n      = 1'b1;
  assign state_dbg = state;

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = A_SET;
          idx_next   = '0;
        end
      end
      A_SET: if (phase_end) state_next = A_WR;
      A_WR:  if (phase_end) state_next = A_HLD;
      A_HLD: if (phase_end) state_next = D_SET;
      D_SET: if (phase_end) state_next = D_WR;
      D_WR:  if (phase_end) state_next = D_HLD;
      D_HLD: begin
        if (phase_end) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            state_next = A_SET;
            idx_next   = idx + 2'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot is taken only on an accepted start, so edits made during a
  // transfer never leak into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (state == IDLE && start) begin
      snap_sec  <= S;
      snap_min  <= M;
      snap_hour <= hour_byte(H, ampm, format);
    end
  end

  always_comb begin
    nxt_addr = ADDR_SEC;
    nxt_data = snap_sec;
    case (idx_next)
      2'd0: begin nxt_addr = ADDR_SEC;  nxt_data = snap_sec;  end
      2'd1: begin nxt_addr = ADDR_MIN;  nxt_data = snap_min;  end
      2'd2: begin nxt_addr = ADDR_HOUR; nxt_data = snap_hour; end
      default: begin nxt_addr = ADDR_CMD; nxt_data = CMD_DATA; end
    endcase
  end

  assign nxt_strobe  = (state_next == A_WR) || (state_next == D_WR);
  assign nxt_addr_ph = (state_next == A_SET) || (state_next == A_WR) ||
                       (state_next == A_HLD);
  assign nxt_data_ph = (state_next == D_SET) || (state_next == D_WR) ||
                       (state_next == D_HLD);

  // Outputs are registered from the next-state decode so they line up
  // with the state register and never glitch on the RTC pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_out <= '0;
      ad_oe  <= 1'b0;
      ad_sel <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ad_oe  <= (state_next != IDLE);
      ad_sel <= nxt_addr_ph;
      ad_out <= nxt_addr_ph ? nxt_addr : (nxt_data_ph ? nxt_data : 8'h00);
      cs_n   <= ~nxt_strobe;
      wr_n   <= ~nxt_strobe;
      busy   <= (state_next != IDLE);
      done   <= (state == D_HLD) && phase_end && (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_rtc_time_writer.sv
// Bench for rtc_time_writer: a T_PHASE=10 instance and a T_PHASE=1 instance
// share inputs and reset; each has its own start. A bus monitor turns
// strobe pulses into (address, data) pairs and checks them against exp_q.
module tb_rtc_time_writer;

  localparam int TP0 = 10;
  localparam int TP1 = 1;

  logic       clk;
  logic       reset;
  logic [7:0] H, M, S;
  logic       ampm, format;
  logic       start_w   [2];
  logic [7:0] ad_out_w  [2];
  logic       ad_oe_w   [2];
  logic       ad_sel_w  [2];
  logic       cs_w      [2];
  logic       wr_w      [2];
  logic       rd_w      [2];
  logic       busy_w    [2];
  logic       done_w    [2];
  logic [2:0] dbg_w     [2];

  int checks;
  int errors;

  logic [15:0] exp_q[$];

  // monitor state, one slot per instance
  logic       m_prev_cs  [2];
  logic [7:0] m_prev_out [2];
  logic       m_prev_sel [2];
  logic [7:0] m_held_out [2];
  logic       m_held_sel [2];
  int         m_low      [2];
  logic [7:0] m_addr     [2];
  logic       m_have     [2];

  typedef struct {
    logic [7:0] h, m, s;
    logic       ap, fmt;
    logic [7:0] exp_hour;
  } vec_t;
  vec_t vecs[5];

  rtc_time_writer dut (
    .clk(clk), .reset(reset), .start(start_w[0]), .H(H), .M(M), .S(S),
    .ampm(ampm), .format(format), .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]),
    .ad_sel(ad_sel_w[0]), .cs_n(cs_w[0]), .wr_n(wr_w[0]), .rd_n(rd_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .state_dbg(dbg_w[0])
  );

  rtc_time_writer #(.T_PHASE(TP1)) dut1 (
    .clk(clk), .reset(reset), .start(start_w[1]), .H(H), .M(M), .S(S),
    .ampm(ampm), .format(format), .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]),
    .ad_sel(ad_sel_w[1]), .cs_n(cs_w[1]), .wr_n(wr_w[1]), .rd_n(rd_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .state_dbg(dbg_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tp_of(input int k);
    return (k == 0) ? TP0 : TP1;
  endfunction

  // Reference: hour register value from the format rules, in plain arithmetic.
  function automatic logic [7:0] model_hour(input int h, input int ap, input int fmt);
    if (fmt == 0) return 8'(h);
    return 8'((h % 32) + 32 * ap);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_clear();
    for (int k = 0; k < 2; k++) begin
      m_prev_cs[k]  = 1'b1;
      m_prev_out[k] = '0;
      m_prev_sel[k] = 1'b0;
      m_held_out[k] = '0;
      m_held_sel[k] = 1'b0;
      m_low[k]      = 0;
      m_addr[k]     = '0;
      m_have[k]     = 1'b0;
    end
  endtask

  task automatic mon_step(input int k);
    logic [15:0] exp_pair;
    if (reset) begin
      return;
    end
    if (rd_w[k] !== 1'b1) check("rd_n_high", rd_w[k], 1);
    if (cs_w[k] !== wr_w[k]) check("cs_wr_together", cs_w[k], wr_w[k]);
    if (!cs_w[k]) begin
      if (m_prev_cs[k]) begin
        // bus value must already be there one cycle before the strobe
        check("setup_value", {ad_sel_w[k], ad_out_w[k]}, {m_prev_sel[k], m_prev_out[k]});
        m_held_out[k] = ad_out_w[k];
        m_held_sel[k] = ad_sel_w[k];
        m_low[k]      = 1;
        check("oe_during_strobe", ad_oe_w[k], 1);
      end else begin
        m_low[k]++;
        if ({ad_sel_w[k], ad_out_w[k]} !== {m_held_sel[k], m_held_out[k]})
          check("stable_in_strobe", {ad_sel_w[k], ad_out_w[k]}, {m_held_sel[k], m_held_out[k]});
      end
    end else if (!m_prev_cs[k]) begin
      check("strobe_width", m_low[k], tp_of(k));
      check("hold_value", {ad_sel_w[k], ad_out_w[k]}, {m_held_sel[k], m_held_out[k]});
      if (m_held_sel[k]) begin
        m_addr[k] = m_held_out[k];
        m_have[k] = 1'b1;
      end else begin
        check("addr_before_data", m_have[k], 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {m_addr[k], m_held_out[k]}, 16'h0);
        end else begin
          exp_pair = exp_q.pop_front();
          check("write_pair", {m_addr[k], m_held_out[k]}, exp_pair);
        end
        m_have[k] = 1'b0;
      end
    end
    m_prev_cs[k]  = cs_w[k];
    m_prev_out[k] = ad_out_w[k];
    m_prev_sel[k] = ad_sel_w[k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) mon_step(k);
  endtask

  task automatic push_expected(input logic [7:0] s, input logic [7:0] m, input logic [7:0] hb);
    exp_q.push_back({8'h21, s});
    exp_q.push_back({8'h22, m});
    exp_q.push_back({8'h23, hb});
    exp_q.push_back({8'hF2, 8'hFF});
  endtask

  // Runs one commit on instance k; poke_cyc > 1 re-pulses start with
  // changed inputs at that cycle, which must have no effect.
  task automatic run_transfer(input int k, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic ap, input logic fmt,
                              input logic [7:0] exp_hour, input int poke_cyc);
    int tp;
    int done_cyc;
    tp = tp_of(k);
    done_cyc = 0;
    push_expected(s, m, exp_hour);
    @(negedge clk);
    H = h; M = m; S = s; ampm = ap; format = fmt;
    start_w[k] = 1'b1;
    for (int cyc = 1; cyc <= 24 * tp + 4; cyc++) begin
      tick();
      if (cyc == 1) begin
        start_w[k] = 1'b0;
        check("busy_after_start", busy_w[k], 1);
      end
      if (cyc == poke_cyc) begin
        H = ~H; M = ~M; S = ~S; ampm = ~ampm; format = ~format;
        start_w[k] = 1'b1;
      end
      if (cyc == poke_cyc + 1) start_w[k] = 1'b0;
      if (done_cyc == 0 && done_w[k]) begin
        done_cyc = cyc;
        check("busy_low_at_done", busy_w[k], 0);
        check("oe_low_at_done", ad_oe_w[k], 0);
        check("ad_out_zero_at_done", ad_out_w[k], 0);
      end else if (done_cyc == 0) begin
        if (busy_w[k] !== 1'b1) check("busy_during_transfer", busy_w[k], 1);
      end else if (cyc == done_cyc + 1) begin
        check("done_one_cycle", done_w[k], 0);
        break;
      end
    end
    check("done_latency", done_cyc, 1 + 24 * tp);
    check("all_writes_seen", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_after_done", {busy_w[k], cs_w[k]}, 2'b01);
    end
  endtask

  task automatic check_reset_state(input int k);
    check("rst_ad_out", ad_out_w[k], 0);
    check("rst_ad_oe", ad_oe_w[k], 0);
    check("rst_ad_sel", ad_sel_w[k], 0);
    check("rst_cs_n", cs_w[k], 1);
    check("rst_wr_n", wr_w[k], 1);
    check("rst_rd_n", rd_w[k], 1);
    check("rst_busy", busy_w[k], 0);
    check("rst_done", done_w[k], 0);
    check("rst_state", dbg_w[k], 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    H = '0; M = '0; S = '0; ampm = 1'b0; format = 1'b0;
    mon_clear();

    vecs[0] = '{h: 8'h14, m: 8'h35, s: 8'h09, ap: 1'b0, fmt: 1'b0, exp_hour: 8'h14};
    vecs[1] = '{h: 8'h07, m: 8'h59, s: 8'h59, ap: 1'b1, fmt: 1'b1, exp_hour: 8'h27};
    vecs[2] = '{h: 8'h12, m: 8'h00, s: 8'h00, ap: 1'b0, fmt: 1'b1, exp_hour: 8'h12};
    vecs[3] = '{h: 8'h23, m: 8'h01, s: 8'h45, ap: 1'b1, fmt: 1'b0, exp_hour: 8'h23};
    vecs[4] = '{h: 8'hFF, m: 8'hAA, s: 8'h55, ap: 1'b1, fmt: 1'b1, exp_hour: 8'h3F};

    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // table-driven commits
    for (int i = 0; i < 5; i++)
      run_transfer(0, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ap, vecs[i].fmt, vecs[i].exp_hour, 0);
    for (int i = 0; i < 2; i++)
      run_transfer(1, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ap, vecs[i].fmt, vecs[i].exp_hour, 0);

    // start re-pulsed mid-transfer with different inputs
    run_transfer(0, 8'h09, 8'h15, 8'h30, 1'b0, 1'b0, 8'h09, 60);
    run_transfer(1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 8'h31, 7);

    // asynchronous reset during the MIN data strobe
    push_expected(8'h42, 8'h17, 8'h05);
    @(negedge clk);
    H = 8'h05; M = 8'h17; S = 8'h42; ampm = 1'b0; format = 1'b0;
    start_w[0] = 1'b1;
    for (int cyc = 1; cyc <= 10 * TP0 + 3; cyc++) begin
      tick();
      if (cyc == 1) start_w[0] = 1'b0;
    end
    check("in_min_dwr", {cs_w[0], ad_sel_w[0], ad_out_w[0]}, {1'b0, 1'b0, 8'h17});
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_cs_n", cs_w[0], 1);
    check("async_wr_n", wr_w[0], 1);
    check("async_oe", ad_oe_w[0], 0);
    check("async_busy", busy_w[0], 0);
    check("async_state", dbg_w[0], 0);
    check("sec_written_before_reset", exp_q.size(), 3);
    exp_q.delete();
    mon_clear();
    @(negedge clk);
    reset = 1'b0;
    run_transfer(0, 8'h08, 8'h30, 8'h00, 1'b1, 1'b1, 8'h28, 0);

    // randomized commits against the reference model
    for (int i = 0; i < 8; i++) begin
      int k, h, m, s, ap, fmt;
      k   = (i < 5) ? 0 : 1;
      h   = $urandom_range(0, 255);
      m   = $urandom_range(0, 255);
      s   = $urandom_range(0, 255);
      ap  = $urandom_range(0, 1);
      fmt = $urandom_range(0, 1);
      run_transfer(k, 8'(h), 8'(m), 8'(s), 1'(ap), 1'(fmt), model_hour(h, ap, fmt), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
